// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS core definitions: opcode constants, hazard
//               controller state encoding and source-operand decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_SW     = 6'h2B;

    typedef enum logic [0:0] {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_t;

    // rt is a true source only for R-type, two-operand branches and stores
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

    // Branches resolved in ID need their operands earlier than EX consumers
    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_REGIMM) ||
               (op == OP_BLEZ) || (op == OP_BGTZ);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Pipeline-field bundle between the ID/EX/MEM stages and the
//               hazard controller, plus the controller's enable/flush outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if;
    logic [5:0] Opcode_IFID;
    logic [4:0] RsAddr_IFID;
    logic [4:0] RtAddr_IFID;
    logic [4:0] WrAddr_IDEX;
    logic       RegWrite_IDEX;
    logic       MemRead_IDEX;
    logic [4:0] RdAddr_EXMEM;
    logic       MemRead_EXMEM;
    logic       BranchTaken;
    logic       Jump;
    logic       PCWrite;
    logic       IFIDWrite;
    logic       IDEXBubble;
    logic       IFIDFlush;

    // Pipeline side: supplies stage fields, consumes the enables
    modport master (
        output Opcode_IFID, RsAddr_IFID, RtAddr_IFID, WrAddr_IDEX, RegWrite_IDEX,
               MemRead_IDEX, RdAddr_EXMEM, MemRead_EXMEM, BranchTaken, Jump,
        input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush
    );

    // Controller side
    modport slave (
        input  Opcode_IFID, RsAddr_IFID, RtAddr_IFID, WrAddr_IDEX, RegWrite_IDEX,
               MemRead_IDEX, RdAddr_EXMEM, MemRead_EXMEM, BranchTaken, Jump,
        output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush
    );
endinterface

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational stall-requirement decode. Returns how many
//               bubbles (0..2) the instruction in ID needs before forwarding
//               can supply its sources.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import mips_pkg::*;
(
    input  wire logic [5:0] opcode,
    input  wire logic [4:0] rs,
    input  wire logic [4:0] rt,
    input  wire logic [4:0] wr_ex,
    input  wire logic       regwrite_ex,
    input  wire logic       memread_ex,
    input  wire logic [4:0] rd_mem,
    input  wire logic       memread_mem,
    output logic      [1:0] need
);

    logic use_rt;
    logic branch;
    logic match_ex;
    logic match_mem;

    // Source matching and stall-count selection; the largest requirement wins
    always_comb begin
        use_rt    = uses_rt(opcode);
        branch    = is_branch(opcode);
        // $zero is never a real dependency
        match_ex  = (wr_ex != 5'd0) && ((wr_ex == rs) || (use_rt && (wr_ex == rt)));
        match_mem = (rd_mem != 5'd0) && ((rd_mem == rs) || (use_rt && (rd_mem == rt)));
        need      = 2'd0;
        if (branch) begin
            if (memread_ex && match_ex) begin
                need = 2'd2;
            end else if ((regwrite_ex && !memread_ex && match_ex) ||
                         (memread_mem && match_mem)) begin
                need = 2'd1;
            end
        end else if (memread_ex && match_ex) begin
            need = 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Inserts load-use and ID-branch
//               stalls, drives PC/IF-ID enables, ID/EX bubble and IF/ID flush.
//               Optional stall/flush statistics counters are built when the
//               HAZARD_CTRL_STATS_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import mips_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    hazard_ctrl_if.slave hz
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
`endif
);

    hz_state_t state;
    hz_state_t state_next;
    logic      cnt;
    logic      cnt_next;
    logic      stall;
    logic      flush;
    logic [1:0] need;

    hazard_detect u_detect (
        .opcode      (hz.Opcode_IFID),
        .rs          (hz.RsAddr_IFID),
        .rt          (hz.RtAddr_IFID),
        .wr_ex       (hz.WrAddr_IDEX),
        .regwrite_ex (hz.RegWrite_IDEX),
        .memread_ex  (hz.MemRead_IDEX),
        .rd_mem      (hz.RdAddr_EXMEM),
        .memread_mem (hz.MemRead_EXMEM),
        .need        (need)
    );

    // State and remaining-stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HZ_RUN;
            cnt   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: a two-bubble hazard stalls now in RUN and once more in STALL
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        case (state)
            HZ_RUN: begin
                stall = (need != 2'd0);
                if (need == 2'd2) begin
                    state_next = HZ_STALL;
                    cnt_next   = 1'b1;
                end
            end
            HZ_STALL: begin
                stall    = 1'b1;
                cnt_next = (cnt == 1'b0) ? 1'b0 : cnt - 1'b1;
                if (cnt_next == 1'b0) begin
                    state_next = HZ_RUN;
                end
            end
            default: begin
                state_next = HZ_RUN;
                cnt_next   = 1'b0;
            end
        endcase
    end

    // Output decode: stall beats flush, and reset forces run values at once
    always_comb begin
        flush         = !rst && !stall && (hz.BranchTaken || hz.Jump);
        hz.PCWrite    = rst || !stall;
        hz.IFIDWrite  = rst || !stall;
        hz.IDEXBubble = !rst && stall;
        hz.IFIDFlush  = flush;
    end

`ifdef HAZARD_CTRL_STATS_EN
    // Saturating stall and flush event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= 16'd0;
            FlushCount <= 16'd0;
        end else begin
            if (stall && (StallCount != 16'hFFFF)) begin
                StallCount <= StallCount + 16'd1;
            end
            if (flush && (FlushCount != 16'hFFFF)) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard testbench for hazard_ctrl. Stimulus pushes expected
//               outputs; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
    import mips_pkg::*;

    typedef struct {
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic        fl;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic clk;
    logic rst;
    hazard_ctrl_if hz();

`ifdef HAZARD_CTRL_STATS_EN
    logic [15:0] StallCount;
    logic [15:0] FlushCount;
`endif

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
`ifdef HAZARD_CTRL_STATS_EN
        ,
        .StallCount (StallCount),
        .FlushCount (FlushCount)
`endif
    );

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks;
    int    n_fail;
    int    sc_model;
    int    fc_model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of pipeline fields and queue its expected outputs
    task automatic step(input logic rst_v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] wex, input logic rwex,
                        input logic mrex, input logic [4:0] rmem, input logic mrmem,
                        input logic bt, input logic j, input logic e_stall,
                        input logic e_fl, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst                 = rst_v;
        hz.Opcode_IFID      = op;
        hz.RsAddr_IFID      = rs;
        hz.RtAddr_IFID      = rt;
        hz.WrAddr_IDEX      = wex;
        hz.RegWrite_IDEX    = rwex;
        hz.MemRead_IDEX     = mrex;
        hz.RdAddr_EXMEM     = rmem;
        hz.MemRead_EXMEM    = mrmem;
        hz.BranchTaken      = bt;
        hz.Jump             = j;
        if (rst_v) begin
            sc_model = 0;
            fc_model = 0;
        end
        e.pcw = !e_stall;
        e.ifw = !e_stall;
        e.bub = e_stall;
        e.fl  = e_fl;
        e.sc  = 16'(sc_model);
        e.fc  = 16'(fc_model);
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (!rst_v) begin
            sc_model += int'(e_stall);
            fc_model += int'(e_fl);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (hz.PCWrite !== e.pcw) begin
                n_fail++;
                $display("FAIL %s PCWrite got %b want %b", nm, hz.PCWrite, e.pcw);
            end
            n_checks++;
            if (hz.IFIDWrite !== e.ifw) begin
                n_fail++;
                $display("FAIL %s IFIDWrite got %b want %b", nm, hz.IFIDWrite, e.ifw);
            end
            n_checks++;
            if (hz.IDEXBubble !== e.bub) begin
                n_fail++;
                $display("FAIL %s IDEXBubble got %b want %b", nm, hz.IDEXBubble, e.bub);
            end
            n_checks++;
            if (hz.IFIDFlush !== e.fl) begin
                n_fail++;
                $display("FAIL %s IFIDFlush got %b want %b", nm, hz.IFIDFlush, e.fl);
            end
`ifdef HAZARD_CTRL_STATS_EN
            n_checks++;
            if (StallCount !== e.sc) begin
                n_fail++;
                $display("FAIL %s StallCount got %0d want %0d", nm, StallCount, e.sc);
            end
            n_checks++;
            if (FlushCount !== e.fc) begin
                n_fail++;
                $display("FAIL %s FlushCount got %0d want %0d", nm, FlushCount, e.fc);
            end
`endif
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sc_model = 0;
        fc_model = 0;
        rst = 1'b1;
        hz.Opcode_IFID = 6'h00; hz.RsAddr_IFID = 5'd0; hz.RtAddr_IFID = 5'd0;
        hz.WrAddr_IDEX = 5'd0; hz.RegWrite_IDEX = 1'b0; hz.MemRead_IDEX = 1'b0;
        hz.RdAddr_EXMEM = 5'd0; hz.MemRead_EXMEM = 1'b0;
        hz.BranchTaken = 1'b0; hz.Jump = 1'b0;

        //    rst  op      rs  rt  wex rw mr rmem mm bt j  stall fl  name
        step(1'b1, 6'h00,  8,  0,  8, 1, 1,  0,  0, 1, 0, 0, 0, "reset_hazard_inputs");
        step(1'b0, 6'h00,  8,  0,  8, 1, 1,  0,  0, 0, 0, 1, 0, "loaduse_stall");
        step(1'b0, 6'h00,  8,  0,  0, 0, 0,  8,  1, 0, 0, 0, 0, "loaduse_resume");
        step(1'b0, OP_BEQ, 9,  8,  8, 1, 1,  0,  0, 0, 0, 1, 0, "ldbr_stall1");
        step(1'b0, OP_BEQ, 9,  8,  0, 0, 0,  8,  1, 1, 0, 1, 0, "ldbr_stall2_taken_ignored");
        step(1'b0, OP_BEQ, 9,  8,  0, 0, 0,  0,  0, 1, 0, 0, 1, "ldbr_resume_flush");
        step(1'b0, OP_BGTZ,8,  0,  8, 1, 0,  0,  0, 0, 0, 1, 0, "alu_br1_rs_stall");
        step(1'b0, OP_BGTZ,9,  8,  8, 1, 0,  0,  0, 0, 0, 0, 0, "alu_br1_rt_unused");
        step(1'b0, 6'h08,  9,  8,  8, 1, 1,  0,  0, 0, 0, 0, 0, "addi_rt_dest_no_stall");
        step(1'b0, 6'h00,  0,  0,  0, 1, 1,  0,  1, 0, 0, 0, 0, "reg0_no_match");
        step(1'b0, OP_BEQ, 1,  2,  8, 1, 1,  8,  1, 1, 0, 0, 1, "beq_taken_flush");
        step(1'b0, 6'h00,  1,  2,  0, 0, 0,  0,  0, 0, 0, 0, 0, "flush_one_cycle");
        step(1'b0, 6'h02,  0,  0,  0, 0, 0,  0,  0, 0, 1, 0, 1, "jump_flush");
        step(1'b0, OP_BNE, 3,  8,  0, 0, 0,  8,  1, 1, 0, 1, 0, "mem_load_branch_stall");
        step(1'b0, OP_BNE, 3,  8,  0, 0, 0,  0,  0, 0, 0, 0, 0, "mem_load_branch_resume");
        step(1'b0, 6'h00,  8,  0,  8, 1, 0,  0,  0, 0, 0, 0, 0, "alu_nonbranch_forwarded");
        step(1'b0, OP_SW,  4,  8,  8, 1, 1,  0,  0, 0, 0, 1, 0, "sw_rt_loaduse");
        step(1'b0, OP_SW,  4,  8,  0, 0, 0,  8,  1, 0, 0, 0, 0, "sw_resume");
        step(1'b0, OP_BEQ, 8,  1,  8, 1, 1,  0,  0, 0, 0, 1, 0, "ldbr2_stall1");
        step(1'b1, OP_BEQ, 8,  1,  0, 0, 0,  8,  1, 1, 0, 0, 0, "reset_mid_stall");
        step(1'b0, 6'h00,  1,  2,  0, 0, 0,  0,  0, 0, 0, 0, 0, "run_after_reset");
        step(1'b0, 6'h00,  8,  0,  8, 1, 1,  0,  0, 0, 0, 1, 0, "loaduse_after_reset");
        step(1'b0, 6'h00,  1,  2,  0, 0, 0,  0,  0, 0, 0, 0, 0, "count_after_loaduse");

        begin : drain
            int budget;
            budget = 0;
            while ((exp_q.size() > 0) && (budget < 20)) begin
                @(posedge clk);
                budget++;
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout pending %0d want 0", exp_q.size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog timeout reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Sits beside the ID stage, upstream of the forwarding unit. Inserts the stall cycles that forwarding cannot cover: load-use, and ID-stage branch compares waiting on results not yet forwardable. Drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush, using a small stall-count state machine.

## Interface
- No parameters.
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- Opcode_IFID  in  6  opcode of instruction in ID
- RsAddr_IFID  in  5  rs of instruction in ID
- RtAddr_IFID  in  5  rt of instruction in ID
- WrAddr_IDEX  in  5  destination register (post-RegDst) of instruction in EX
- RegWrite_IDEX  in  1  EX instruction writes a register
- MemRead_IDEX  in  1  EX instruction is a load
- RdAddr_EXMEM  in  5  destination register of instruction in MEM
- MemRead_EXMEM  in  1  MEM instruction is a load
- BranchTaken  in  1  ID compare resolved taken (valid only when not stalling)
- Jump  in  1  ID instruction is j/jal/jr
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register enable
- IDEXBubble  out  1  zero ID/EX control fields
- IFIDFlush  out  1  clear IF/ID to nop on next edge
- StallCount, FlushCount  out  16 each  only with HAZARD_CTRL_STATS_EN

## Operation
- Source usage: rs always considered; rt used only for opcode 0x00, 0x04, 0x05, 0x2B.
- Branch classes: BR2 = 0x04/0x05 (rs, rt); BR1 = 0x01/0x06/0x07 (rs only).
- Register 0 never matches.
- Required stalls N, from the ID instruction:
  - Non-branch, load in EX writing a used source: N=1.
  - Branch, load in EX writing a used source: N=2.
  - Branch, non-load write in EX (RegWrite_IDEX, !MemRead_IDEX) to a used source: N=1.
  - Branch, load in MEM (MemRead_EXMEM) writing a used source: N=1.
  - Otherwise N=0. When several conditions hold, take the maximum.
- FSM states:
  - RUN: if N≥1, stall this cycle. If N=2, go to STALL with cnt=1; otherwise stay in RUN and re-evaluate next cycle.
  - STALL: stall unconditionally, ignore inputs, decrement cnt. At cnt=0 return to RUN.
- Stall outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
- Not stalling: PCWrite=1, IFIDWrite=1, IDEXBubble=0. IFIDFlush = BranchTaken | Jump.
- Priority: stall over flush. BranchTaken/Jump are ignored in any stalled cycle.

## Timing
- All outputs are combinational from the current state and inputs, and valid in the same cycle as the hazard. Zero latency.
- Load-use: exactly 1 bubble. Load→branch: exactly 2 consecutive bubbles. ALU→branch: exactly 1 bubble.
- Flush is asserted for the single cycle the taken branch/jump occupies ID.
- Reset (async, any state, including mid-STALL):
  - state=RUN, cnt=0, counters=0.
  - Outputs while rst=1: PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0.
- cnt is 1 bit wide; no wrap is possible.

## Configuration
- HAZARD_CTRL_STATS_EN defined:
  - StallCount increments once per stalled cycle.
  - FlushCount increments once per cycle with IFIDFlush=1.
  - Both saturate at 16'hFFFF; reset to 0.
- Undefined: both counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package mips_pkg holds:
  - Opcode constants: OP_RTYPE 6'h00, OP_REGIMM 6'h01, OP_BEQ 6'h04, OP_BNE 6'h05, OP_BLEZ 6'h06, OP_BGTZ 6'h07, OP_SW 6'h2B.
  - State enum: HZ_RUN, HZ_STALL.
- Sub-module hazard_detect: purely combinational, computes N[1:0] from the ID/EX/MEM fields. hazard_ctrl holds the FSM, the output decode and the optional counters.

## Test plan
- lw $t0 (WrAddr_IDEX=8, MemRead_IDEX=1); ID = add rs=8 (opcode 0x00) -> one cycle PCWrite=0, IDEXBubble=1, then normal.
- lw writing 8 in EX; ID = beq rs=9 rt=8 -> two consecutive stall cycles, third cycle PCWrite=1.
- add writing 8 in EX (RegWrite_IDEX=1, MemRead=0); ID = bgtz rs=8 -> 1 stall. Same case with ID = bgtz rt=8 -> no stall.
- lw writing 8 in EX; ID = addi rt=8 (opcode 0x08) -> no stall. WrAddr=0 with any source 0 -> no stall.
- ID = beq, BranchTaken=1, no hazard -> IFIDFlush=1 for 1 cycle. BranchTaken=1 during STALL -> IFIDFlush=0.
- rst pulsed in 2nd cycle of load→branch stall -> outputs return to run values immediately. With HAZARD_CTRL_STATS_EN, StallCount=0 after reset and 1 after a single load-use.
